// File: rtl/enet_mac_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs bytes little-endian into 32-bit
// words, checks the 802.3 FCS and flags the last word with tlast/crc_valid.
module enet_mac_rx_framer #(
  parameter int MAX_WORDS = 512
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_ce_i,
  input  logic        rx_dv_i,
  input  logic        rx_er_i,
  input  logic [3:0]  rx_d_i,
  output logic        outport_tvalid_o,
  output logic [31:0] outport_tdata_o,
  output logic [3:0]  outport_tstrb_o,
  output logic        outport_tlast_o,
  output logic        outport_crc_valid_o
);

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [9:0]  LAST_W  = 10'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] word_q, word_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [1:0]  lane_q, lane_d;
  logic        nib_hi_q, nib_hi_d;
  logic [3:0]  low_q, low_d;
  logic [9:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic        any_q, any_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tstrb_q, tstrb_d;
  logic        tlast_q, tlast_d;
  logic        crcok_q, crcok_d;
  logic [7:0]  byte_v;
  logic        good_v;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    word_d     = word_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    lane_d     = lane_q;
    nib_hi_d   = nib_hi_q;
    low_d      = low_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    any_d      = any_q;
    tvalid_d   = 1'b0;
    tdata_d    = '0;
    tstrb_d    = '0;
    tlast_d    = 1'b0;
    crcok_d    = 1'b0;
    byte_v     = {rx_d_i, low_q};
    // An odd trailing nibble (nib_hi_q still set) always spoils the frame.
    good_v     = (crc_q == RESIDUE) && !err_q && !nib_hi_q && any_q;
    if (rx_ce_i) begin
      unique case (state_q)
        IDLE: if (rx_dv_i) state_d = (rx_d_i == 4'h5) ? PREAMBLE : DISCARD;
        PREAMBLE: begin
          if (!rx_dv_i)               state_d = IDLE;
          else if (rx_d_i == 4'hD) begin
            state_d    = DATA;
            crc_d      = '1;
            word_d     = '0;
            hold_vld_d = 1'b0;
            lane_d     = '0;
            nib_hi_d   = 1'b0;
            wcnt_d     = '0;
            err_d      = 1'b0;
            any_d      = 1'b0;
          end else if (rx_d_i != 4'h5) state_d = DISCARD;
        end
        DATA: begin
          if (rx_dv_i) begin
            crc_d = crc_nib(crc_q, rx_d_i);
            err_d = err_q | rx_er_i;
            if (!nib_hi_q) begin
              low_d    = rx_d_i;
              nib_hi_d = 1'b1;
            end else begin
              nib_hi_d = 1'b0;
              word_d[{lane_q, 3'b000} +: 8] = byte_v;
              if (lane_q == 2'd3) begin
                hold_d     = word_d;
                hold_vld_d = 1'b1;
                any_d      = 1'b1;
                word_d     = '0;
                lane_d     = '0;
              end else begin
                lane_d = lane_q + 2'd1;
              end
              // First byte of a new word proves the held word is not the last.
              if (lane_q == 2'd0 && hold_vld_q) begin
                tvalid_d   = 1'b1;
                tdata_d    = hold_q;
                tstrb_d    = 4'hF;
                hold_vld_d = 1'b0;
                wcnt_d     = wcnt_q + 10'd1;
                if (wcnt_q == LAST_W) begin
                  tlast_d = 1'b1;
                  state_d = DISCARD;
                end
              end
            end
          end else begin
            state_d = IDLE;
            if (lane_q != 2'd0) begin
              tvalid_d = 1'b1;
              tdata_d  = word_q;
              tstrb_d  = ~(4'hF << lane_q);
              tlast_d  = 1'b1;
              crcok_d  = good_v;
            end else if (hold_vld_q) begin
              tvalid_d = 1'b1;
              tdata_d  = hold_q;
              tstrb_d  = 4'hF;
              tlast_d  = 1'b1;
              crcok_d  = good_v;
            end
          end
        end
        DISCARD: if (!rx_dv_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      crc_q      <= '1;
      word_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      lane_q     <= '0;
      nib_hi_q   <= 1'b0;
      low_q      <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      any_q      <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tstrb_q    <= '0;
      tlast_q    <= 1'b0;
      crcok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      word_q     <= word_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      lane_q     <= lane_d;
      nib_hi_q   <= nib_hi_d;
      low_q      <= low_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      any_q      <= any_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tstrb_q    <= tstrb_d;
      tlast_q    <= tlast_d;
      crcok_q    <= crcok_d;
    end
  end

  assign outport_tvalid_o    = tvalid_q;
  assign outport_tdata_o     = tdata_q;
  assign outport_tstrb_o     = tstrb_q;
  assign outport_tlast_o     = tlast_q;
  assign outport_crc_valid_o = crcok_q;

endmodule
